// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
//
// Multi-cycle RV32M multiply/divide unit for the execute stage. It takes one
// request at a time over a valid/ready handshake and iterates one bit per
// cycle. Multiply uses radix-2 shift-add and divide uses restoring
// shift-subtract, both on operand magnitudes. Signs are applied in a single
// FIXUP cycle at the end. Divide-by-zero and signed overflow bypass the
// iteration and complete at acceptance.
//
// Optional feature: define ALU_MULDIV_FAST_MUL_EN to make all multiply ops
// single-cycle through a (2*XLEN)-bit multiplier. Divides are not affected.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous abort of any in-flight operation
//   in_valid   request valid
//   in_ready   unit can accept a request (IDLE and no flush)
//   op         funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   op1, op2   rs1 / rs2 operands
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer takes result
//   result     registered result
//   busy       unit is not IDLE
// -----------------------------------------------------------------------------
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t              r_state, w_next_state;
  logic [2:0]          r_op;
  logic                r_neg_a, r_neg_b;
  logic [XLEN-1:0]     r_b;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_result;

  // ---------------------------------------------------------------------------
  // Acceptance-time decode on the live inputs
  // ---------------------------------------------------------------------------
  logic            w_accept, w_sign_a, w_sign_b, w_neg_a, w_neg_b;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_div_zero, w_div_ovf, w_fast_mul, w_fast;
  logic [XLEN-1:0] w_fast_res;

  assign w_accept = in_valid && in_ready;
  assign w_sign_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign w_sign_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign w_neg_a  = w_sign_a && op1[XLEN-1];
  assign w_neg_b  = w_sign_b && op2[XLEN-1];
  assign w_mag_a  = w_neg_a ? -op1 : op1;
  assign w_mag_b  = w_neg_b ? -op2 : op2;

  assign w_div_zero = op[2] && (op2 == '0);
  assign w_div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                      (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_ext_a, w_ext_b, w_full;
  // Sign-extend to 2*XLEN; the truncated unsigned product is then the
  // correct two's-complement product for every signedness combination.
  assign w_ext_a    = {{XLEN{w_neg_a}}, op1};
  assign w_ext_b    = {{XLEN{w_neg_b}}, op2};
  assign w_full     = w_ext_a * w_ext_b;
  assign w_fast_mul = !op[2];
`else
  assign w_fast_mul = 1'b0;
`endif

  assign w_fast = w_div_zero || w_div_ovf || w_fast_mul;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_fast_res = '0;
    // op[1] separates REM/REMU from DIV/DIVU within the divide group.
    if (w_div_zero)     w_fast_res = op[1] ? op1 : '1;
    else if (w_div_ovf) w_fast_res = op[1] ? '0 : op1;
`ifdef ALU_MULDIV_FAST_MUL_EN
    else if (w_fast_mul) w_fast_res = (op == OP_MUL) ? w_full[XLEN-1:0] : w_full[2*XLEN-1:XLEN];
`endif
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic [2*XLEN-1:0] w_mul_next, w_div_next;

  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  // A borrow out of the trial subtraction means the divisor did not fit:
  // keep the shifted remainder and shift in a 0 quotient bit.
  assign w_div_next  = w_div_diff[XLEN] ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                        : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

  // ---------------------------------------------------------------------------
  // Sign fix-up and result selection
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

  assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
  assign w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = w_prod[2*XLEN-1:XLEN];
    if (r_op == OP_MUL)  w_fix_res = w_prod[XLEN-1:0];
    else if (r_op[2])    w_fix_res = r_op[1] ? w_rem : w_quo;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_next_state = w_fast ? S_DONE : S_CALC;
        S_CALC:  if (r_cnt == CNT_W'(1)) w_next_state = S_FIXUP;
        S_FIXUP: w_next_state = S_DONE;
        S_DONE:  if (out_ready) w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (!flush) begin
      if (r_state == S_IDLE && w_accept) begin
        r_op    <= op;
        r_neg_a <= w_neg_a;
        r_neg_b <= w_neg_b;
        r_b     <= w_mag_b;
        r_acc   <= {{XLEN{1'b0}}, w_mag_a};
        r_cnt   <= CNT_W'(XLEN);
        if (w_fast) r_result <= w_fast_res;
      end else if (r_state == S_CALC) begin
        r_acc <= r_op[2] ? w_div_next : w_mul_next;
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (r_state == S_FIXUP) begin
        r_result <= w_fix_res;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !flush;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;

endmodule

// File: tb/tb_alu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv
//
// Directed bench for alu_muldiv (XLEN=32). Latency is counted in rising
// edges after the acceptance edge: the iterative path lands in DONE 33 edges
// later, fast-path results are already valid in the cycle right after
// acceptance (0 further edges). Outputs are sampled 1 time unit after the
// rising edge or on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_muldiv;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] op1, op2, result;
  int          checks = 0;
  int          failures = 0;
  int          lat;

`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int FAST_LAT = 0;

  alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op1(op1), .op2(op2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for one edge, then scramble the inputs to make sure
  // only the latched copies are used.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); op1 = $urandom; op2 = $urandom;
  endtask

  // Count edges after acceptance until out_valid, bounded.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; op1 = '0; op2 = '0;

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_result",    result,         32'h0);
    @(negedge clk); rst = 1'b0;

    // MULHU all-ones: high half of 0xFFFFFFFE_00000001
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhu", lat);
    check("mulhu_lat", 32'(lat), 32'(MUL_LAT));
    check("mulhu_res", result, 32'hFFFF_FFFE);
    take();
    check("mulhu_idle", 32'(in_ready), 32'd1);

    // DIV -7/2 = -3, REM -7%2 = -1
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", lat);
    check("div_lat", 32'(lat), 32'(DIV_LAT));
    check("div_res", result, 32'hFFFF_FFFD);
    take();
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    wait_done("rem", lat);
    check("rem_res", result, 32'hFFFF_FFFF);
    take();

    // MULHSU -1 * 0xFFFFFFFF = 0xFFFFFFFF_00000001
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhsu", lat);
    check("mulhsu_res", result, 32'hFFFF_FFFF);
    take();

    // Fast path: divide by zero and signed overflow
    issue(3'd5, 32'd7, 32'd0);
    wait_done("divu0", lat);
    check("divu0_lat", 32'(lat), 32'(FAST_LAT));
    check("divu0_res", result, 32'hFFFF_FFFF);
    take();
    issue(3'd7, 32'd7, 32'd0);
    wait_done("remu0", lat);
    check("remu0_lat", 32'(lat), 32'(FAST_LAT));
    check("remu0_res", result, 32'h0000_0007);
    take();
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("divovf", lat);
    check("divovf_lat", 32'(lat), 32'(FAST_LAT));
    check("divovf_res", result, 32'h8000_0000);
    take();
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("removf", lat);
    check("removf_lat", 32'(lat), 32'(FAST_LAT));
    check("removf_res", result, 32'h0000_0000);
    take();

    // Backpressure: MUL 3*5 held for 5 cycles
    issue(3'd0, 32'd3, 32'd5);
    wait_done("mul35", lat);
    check("mul35_lat", 32'(lat), 32'(MUL_LAT));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_res",      result,         32'h0000_000F);
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready),  32'd0);
    end
    take();
    check("bp_rel_valid",    32'(out_valid), 32'd0);
    check("bp_rel_in_ready", 32'(in_ready),  32'd1);

    // Flush 10 cycles into a DIVU; a request offered during flush is ignored
    issue(3'd5, 32'd1000, 32'd3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("fl_pre_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; op1 = 32'd9; op2 = 32'd9;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("fl_busy",   32'(busy),      32'd0);
    check("fl_valid",  32'(out_valid), 32'd0);
    check("fl_result", result,         32'h0000_000F);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("fl_post_valid", 32'(out_valid), 32'd0);
    end
    check("fl_post_busy", 32'(busy), 32'd0);
    issue(3'd0, 32'd6, 32'd7);
    wait_done("mul67", lat);
    check("mul67_res", result, 32'h0000_002A);
    take();

    // Asynchronous reset mid-CALC
    issue(3'd4, 32'd12345, 32'd11);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid",  32'(out_valid), 32'd0);
    check("arst_busy",   32'(busy),      32'd0);
    check("arst_result", result,         32'h0);
    @(negedge clk); rst = 1'b0;
    issue(3'd7, 32'd100, 32'd7);
    wait_done("remu", lat);
    check("remu_lat", 32'(lat), 32'(DIV_LAT));
    check("remu_res", result, 32'h0000_0002);
    take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
